// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock display path.
//   - mode_e      : mode_select encodings (run / set sec / set min / set hour)
//   - limit_e     : range selector for the binary-to-BCD converter
//   - disp_t      : one registered display word {anode_n, seg_n, dp_n}
//   - NUM_DIGITS  : number of multiplexed digits
//   - SEG_BLANK / SEG_DASH and the 0-9 segment table (seg_of_bcd)
// All segment patterns are {g,f,e,d,c,b,a}, active-low.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_SEC  = 2'b01,
    MODE_MIN  = 2'b10,
    MODE_HOUR = 2'b11
  } mode_e;

  typedef enum logic {
    LIMIT_59 = 1'b0,
    LIMIT_23 = 1'b1
  } limit_e;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef struct packed {
    logic [5:0] anode_n;
    logic [6:0] seg_n;
    logic       dp_n;
  } disp_t;

  // Everything dark: used both for reset and for the anti-ghosting gap.
  localparam disp_t DISP_DARK = '{anode_n: 6'b111111, seg_n: SEG_BLANK, dp_n: 1'b1};

  // Digit segment table. Codes above 9 never reach here in normal use
  // (the converter flags them invalid); they fall back to a dash.
  function automatic logic [6:0] seg_of_bcd(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_60.sv
// Combinational binary-to-BCD conversion for one clock field.
// Ports:
//   value     in  6  binary field value
//   limit_sel in  1  LIMIT_23 for hours, LIMIT_59 for minutes/seconds
//   tens      out 4  value / 10
//   ones      out 4  value % 10
//   valid     out 1  value is within the selected limit
module bin2bcd_60
  import clock_pkg::*;
(
  input  logic [5:0] value,
  input  logic       limit_sel,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       valid
);

  logic [5:0] rem;

  // Repeated subtraction of 10: a 6-bit input needs at most six steps,
  // after which the remainder is always below 10.
  always_comb begin
    rem  = value;
    tens = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    ones = rem[3:0];
  end

  always_comb begin
    if (limit_sel == LIMIT_23) begin
      valid = (value <= 6'd23);
    end else begin
      valid = (value <= 6'd59);
    end
  end

endmodule

// File: rtl/clock_display_scan.sv
// Display back-end for the digital clock: snapshots the timer's hour,
// minute and second once per frame, converts them to BCD and scans a
// 6-digit common-anode 7-segment display. The field being set flashes.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   hour_in       6  binary hours (0..23 valid)
//   minute_in     6  binary minutes (0..59 valid)
//   second_in     6  binary seconds (0..59 valid)
//   mode_select   2  00 run, 01 set sec, 10 set min, 11 set hour
//   enable_5hz    1  single-cycle 5 Hz strobe driving the blink rate
//   anode_n       6  digit enables, active-low; bit0 = sec ones .. bit5 = hour tens
//   seg_n         7  segments {g,f,e,d,c,b,a}, active-low
//   dp_n          1  decimal point, active-low (lit on digits 2 and 4)
// All outputs are registered and reflect the scan position one cycle late.
module clock_display_scan
  import clock_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_TICKS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] hour_in,
  input  logic [5:0] minute_in,
  input  logic [5:0] second_in,
  input  logic [1:0] mode_select,
  input  logic       enable_5hz,
  output logic [5:0] anode_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int DIV_W   = $clog2(REFRESH_DIV);
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0]   BLANK_LIMIT = DIV_W'(BLANK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [2:0]         DIGIT_LAST  = 3'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0]   div_cnt_q,     div_cnt_d;
  logic [2:0]         digit_idx_q,   digit_idx_d;
  logic [5:0]         hour_snap_q,   hour_snap_d;
  logic [5:0]         minute_snap_q, minute_snap_d;
  logic [5:0]         second_snap_q, second_snap_d;
  logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  disp_t              disp_q,        disp_d;

  logic slot_end;
  logic frame_end;

  // ---------------------------------------------------------------------
  // Scan counter and digit index
  // ---------------------------------------------------------------------
  always_comb begin
    slot_end    = (div_cnt_q == DIV_LAST);
    frame_end   = slot_end && (digit_idx_q == DIGIT_LAST);
    div_cnt_d   = div_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (slot_end) begin
      div_cnt_d = '0;
      if (digit_idx_q == DIGIT_LAST) begin
        digit_idx_d = 3'd0;
      end else begin
        digit_idx_d = digit_idx_q + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Snapshot: all three fields are captured together on the last cycle
  // of a frame, so one frame never mixes old and new time values.
  // ---------------------------------------------------------------------
  always_comb begin
    hour_snap_d   = hour_snap_q;
    minute_snap_d = minute_snap_q;
    second_snap_d = second_snap_q;
    if (frame_end) begin
      hour_snap_d   = hour_in;
      minute_snap_d = minute_in;
      second_snap_d = second_in;
    end
  end

  // ---------------------------------------------------------------------
  // Blink phase: free-running, independent of mode so that entering a
  // set mode does not restart the flash cadence.
  // ---------------------------------------------------------------------
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (enable_5hz) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // BCD conversion of the snapshot registers
  // ---------------------------------------------------------------------
  logic [3:0] hour_tens,   hour_ones;
  logic [3:0] minute_tens, minute_ones;
  logic [3:0] second_tens, second_ones;
  logic       hour_valid,  minute_valid, second_valid;

  bin2bcd_60 u_hour_bcd (
    .value     (hour_snap_q),
    .limit_sel (LIMIT_23),
    .tens      (hour_tens),
    .ones      (hour_ones),
    .valid     (hour_valid)
  );

  bin2bcd_60 u_minute_bcd (
    .value     (minute_snap_q),
    .limit_sel (LIMIT_59),
    .tens      (minute_tens),
    .ones      (minute_ones),
    .valid     (minute_valid)
  );

  bin2bcd_60 u_second_bcd (
    .value     (second_snap_q),
    .limit_sel (LIMIT_59),
    .tens      (second_tens),
    .ones      (second_ones),
    .valid     (second_valid)
  );

  // ---------------------------------------------------------------------
  // Digit mux and next display word
  // ---------------------------------------------------------------------
  logic [3:0] digit_val;
  logic       digit_valid;
  mode_e      digit_field;  // the set-mode that owns the current digit
  logic       blink_hide;
  logic       in_blank;
  logic [6:0] digit_seg;

  always_comb begin
    digit_val   = 4'd0;
    digit_valid = 1'b0;
    digit_field = MODE_RUN;
    case (digit_idx_q)
      3'd0: begin digit_val = second_ones; digit_valid = second_valid; digit_field = MODE_SEC;  end
      3'd1: begin digit_val = second_tens; digit_valid = second_valid; digit_field = MODE_SEC;  end
      3'd2: begin digit_val = minute_ones; digit_valid = minute_valid; digit_field = MODE_MIN;  end
      3'd3: begin digit_val = minute_tens; digit_valid = minute_valid; digit_field = MODE_MIN;  end
      3'd4: begin digit_val = hour_ones;   digit_valid = hour_valid;   digit_field = MODE_HOUR; end
      3'd5: begin digit_val = hour_tens;   digit_valid = hour_valid;   digit_field = MODE_HOUR; end
      default: begin
        digit_val   = 4'd0;
        digit_valid = 1'b0;
        digit_field = MODE_RUN;
      end
    endcase
  end

  always_comb begin
    // mode_select is used live (not snapshotted) so mode changes show up
    // on the very next registered output.
    blink_hide = (mode_e'(mode_select) != MODE_RUN) &&
                 (mode_e'(mode_select) == digit_field) &&
                 blink_phase_q;

    if (blink_hide) begin
      digit_seg = SEG_BLANK;
    end else if (!digit_valid) begin
      digit_seg = SEG_DASH;
    end else begin
      digit_seg = seg_of_bcd(digit_val);
    end

    in_blank = (BLANK_CYCLES > 0) && (div_cnt_q < BLANK_LIMIT);

    disp_d = DISP_DARK;
    if (!in_blank) begin
      disp_d.anode_n = ~(6'b000001 << digit_idx_q);
      disp_d.seg_n   = digit_seg;
      // Separators sit on the ones digits of minutes and hours: HH.MM.SS
      disp_d.dp_n    = !((digit_idx_q == 3'd2) || (digit_idx_q == 3'd4));
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      digit_idx_q   <= 3'd0;
      hour_snap_q   <= 6'd0;
      minute_snap_q <= 6'd0;
      second_snap_q <= 6'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      disp_q        <= DISP_DARK;
    end else begin
      div_cnt_q     <= div_cnt_d;
      digit_idx_q   <= digit_idx_d;
      hour_snap_q   <= hour_snap_d;
      minute_snap_q <= minute_snap_d;
      second_snap_q <= second_snap_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      disp_q        <= disp_d;
    end
  end

  assign anode_n = disp_q.anode_n;
  assign seg_n   = disp_q.seg_n;
  assign dp_n    = disp_q.dp_n;

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan with a small scan period. A reference model
// derives every expected display word from a global cycle number since
// reset, a count of blink strobes and a per-frame copy of the inputs.
module tb_clock_display_scan;

  localparam int RD = 4;
  localparam int BL = 1;
  localparam int BT = 2;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] hour_in = 6'd0;
  logic [5:0] minute_in = 6'd0;
  logic [5:0] second_in = 6'd0;
  logic [1:0] mode_select = 2'b00;
  logic       enable_5hz = 1'b0;
  logic [5:0] anode_n;
  logic [6:0] seg_n;
  logic       dp_n;

  always #5 clk = ~clk;

  clock_display_scan #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BL),
    .BLINK_TICKS  (BT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hour_in     (hour_in),
    .minute_in   (minute_in),
    .second_in   (second_in),
    .mode_select (mode_select),
    .enable_5hz  (enable_5hz),
    .anode_n     (anode_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n)
  );

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  int n_total = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  localparam logic [6:0] REF_SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  int m_n = 0;       // cycles since reset release
  int m_pulses = 0;  // blink strobes since reset
  int m_s = 0, m_m = 0, m_h = 0;
  int m_dig = 7, m_pos = 7;  // slot/position of the word just produced
  logic [13:0] exp_q[$];

  function automatic logic [13:0] ref_out(input int n, input int pulses,
                                          input int s, input int m, input int h,
                                          input int mode);
    int pos, dig, field, v, lim, d;
    logic [5:0] an;
    logic [6:0] sg;
    logic dp;
    pos = n % RD;
    dig = (n / RD) % 6;
    if (pos < BL) return {6'b111111, 7'h7F, 1'b1};
    field = dig / 2;
    v   = (field == 0) ? s : (field == 1) ? m : h;
    lim = (field == 2) ? 23 : 59;
    d   = (dig % 2 == 0) ? (v % 10) : (v / 10);
    if (mode != 0 && ((pulses / BT) % 2 == 1) && field == mode - 1) sg = 7'h7F;
    else if (v > lim) sg = 7'b0111111;
    else sg = REF_SEG[d];
    an = 6'b111111;
    an[dig] = 1'b0;
    dp = (dig == 2 || dig == 4) ? 1'b0 : 1'b1;
    return {an, sg, dp};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.push_back({6'b111111, 7'h7F, 1'b1});
      m_n <= 0;
      m_pulses <= 0;
      m_s <= 0; m_m <= 0; m_h <= 0;
      m_dig <= 7; m_pos <= 7;
    end else begin
      exp_q.push_back(ref_out(m_n, m_pulses, m_s, m_m, m_h, int'(mode_select)));
      m_dig <= (m_n / RD) % 6;
      m_pos <= m_n % RD;
      m_n <= m_n + 1;
      if ((m_n % RD == RD - 1) && ((m_n / RD) % 6 == 5)) begin
        m_s <= int'(second_in);
        m_m <= int'(minute_in);
        m_h <= int'(hour_in);
      end
      if (enable_5hz) m_pulses <= m_pulses + 1;
    end
  end

  // Scoreboard: every registered output word is compared.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check_val("scan_out", {anode_n, seg_n, dp_n}, exp_q.pop_front());
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic wait_slot(input int dig, input int pos);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!(m_dig == dig && m_pos == pos) && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 60) check_val("slot_timeout", m_dig * 8 + m_pos, dig * 8 + pos);
  endtask

  task automatic pulse_5hz();
    enable_5hz = 1'b1;
    @(negedge clk);
    enable_5hz = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence, then randomized run
  // ---------------------------------------------------------------------
  logic [6:0] vals_seg [6] = '{7'b0010010, 7'b0011001, 7'b0010000,
                               7'b0010010, 7'b0110000, 7'b0100100};

  initial begin
    logic [5:0] an;

    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_anode", anode_n, 6'b111111);
    check_val("rst_seg", seg_n, 7'h7F);
    check_val("rst_dp", dp_n, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("first_anode", anode_n, 6'b111110);
    check_val("first_seg", seg_n, 7'b1000000);

    // Values 23:59:45
    hour_in = 6'd23; minute_in = 6'd59; second_in = 6'd45;
    wait_slot(5, 3);
    for (int d = 0; d < 6; d++) begin
      wait_slot(d, 0);
      check_val("val_blank", anode_n, 6'b111111);
      wait_slot(d, 1);
      an = 6'b111111;
      an[d] = 1'b0;
      check_val("val_anode", anode_n, an);
      check_val("val_seg", seg_n, vals_seg[d]);
      check_val("val_dp", dp_n, (d == 2 || d == 4) ? 1'b0 : 1'b1);
    end

    // Blink on minutes
    mode_select = 2'b10;
    pulse_5hz();
    pulse_5hz();
    wait_slot(3, 2);
    check_val("blink_seg", seg_n, 7'h7F);
    check_val("blink_anode", anode_n, 6'b110111);
    wait_slot(4, 2);
    check_val("blink_other", seg_n, 7'b0110000);
    wait_slot(2, 2);
    check_val("blink_dp", dp_n, 1'b0);
    check_val("blink_seg2", seg_n, 7'h7F);
    pulse_5hz();
    pulse_5hz();
    wait_slot(2, 2);
    check_val("blink_back", seg_n, 7'b0010000);

    // Tearing: seconds change mid-frame
    mode_select = 2'b00;
    wait_slot(2, 1);
    second_in = 6'd46;
    wait_slot(5, 2);
    check_val("tear_hour", seg_n, 7'b0100100);
    wait_slot(0, 2);
    check_val("tear_next", seg_n, 7'b0000010);

    // Out-of-range minutes and hours
    minute_in = 6'd60; hour_in = 6'd24;
    wait_slot(5, 3);
    wait_slot(0, 2);
    check_val("inv_sec0", seg_n, 7'b0000010);
    wait_slot(1, 2);
    check_val("inv_sec1", seg_n, 7'b0011001);
    for (int d = 2; d < 6; d++) begin
      wait_slot(d, 2);
      check_val("inv_dash", seg_n, 7'b0111111);
    end

    // Mid-frame reset
    wait_slot(3, 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_anode", anode_n, 6'b111111);
    check_val("mid_rst_seg", seg_n, 7'h7F);
    check_val("mid_rst_dp", dp_n, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("mid_rst_first", anode_n, 6'b111110);
    check_val("mid_rst_zero", seg_n, 7'b1000000);

    // Randomized run
    hour_in = 6'd12; minute_in = 6'd34; second_in = 6'd56;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) mode_select = 2'($urandom_range(0, 3));
      enable_5hz = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) begin
        hour_in   = 6'($urandom_range(0, 25));
        minute_in = 6'($urandom_range(0, 61));
        second_in = 6'($urandom_range(0, 61));
      end
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    enable_5hz = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
